bit_block_counter_p: RTL

Parametrised successor to the fixed 32-bit bit-block counter. Accepts a DATA_W-bit word under a ready/enable handshake and scans it CHUNK_W bits per clock, LSB first. Reports the number of maximal runs of a selectable target bit value (1s or 0s) whose length is at least a programmable minimum, plus the longest run found. Sits in the datapath between the word source and any statistics consumer that samples on `valid`.

---
 rtl/bit_block_pkg.sv | 16 +
 rtl/bit_block_counter_p_chunk_scan.sv | 53 +++++
 rtl/bit_block_counter_p.sv | 130 +++++++++++++
 3 files changed

// File: rtl/bit_block_pkg.sv
// Shared definitions for the bit-block counter: FSM state encoding and the
// helper that sizes the length/count fields from the word width.
package bit_block_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to hold any run length or run count from 0 to data_w.
    function automatic int len_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/bit_block_counter_p_chunk_scan.sv
// Combinational scan of one chunk. The target bit is always 1 here because
// the top level inverts the word when counting runs of 0s. A run open at
// the chunk's MSB is carried out through run_len_out. On the last chunk,
// that open run is closed instead of being carried.
module bit_block_chunk_scan
    import bit_block_pkg::*;
#(
    parameter int CHUNK_W = 8,
    parameter int LEN_W   = 6
) (
    input  logic [CHUNK_W-1:0] chunk,
    input  logic [LEN_W-1:0]   run_len_in,
    input  logic [LEN_W-1:0]   min_len,
    input  logic               last_chunk,
    output logic [LEN_W-1:0]   cnt_inc,
    output logic [LEN_W-1:0]   run_len_out,
    output logic [LEN_W-1:0]   chunk_max
);

    logic [LEN_W-1:0] eff_min;
    logic [LEN_W-1:0] run;
    logic [LEN_W-1:0] inc;
    logic [LEN_W-1:0] mx;

    // A minimum of 0 behaves like 1, because an empty run is never a block.
    assign eff_min = (min_len == '0) ? LEN_W'(1) : min_len;

    // Walk the chunk LSB first. Extend the run on a target bit, and close
    // and qualify it on a non-target bit.
    always_comb begin
        run = run_len_in;
        inc = '0;
        mx  = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            if (chunk[i]) begin
                run = run + LEN_W'(1);
            end else begin
                if (run != '0 && run >= eff_min) inc = inc + LEN_W'(1);
                if (run > mx) mx = run;
                run = '0;
            end
        end
        if (last_chunk) begin
            if (run != '0 && run >= eff_min) inc = inc + LEN_W'(1);
            if (run > mx) mx = run;
            run = '0;
        end
        cnt_inc     = inc;
        run_len_out = run;
        chunk_max   = mx;
    end

endmodule

// File: rtl/bit_block_counter_p.sv
// Bit-block counter. It accepts a word on the ready/data_enb handshake and
// scans the word CHUNK_W bits per clock, LSB first. It then reports two
// results:
//   - the number of maximal target-bit runs at least min_len long;
//   - the longest target-bit run.
module bit_block_counter_p
    import bit_block_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int CHUNK_W = 8,
    localparam int LEN_W   = len_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              data_enb,
    input  logic              polarity,
    input  logic [LEN_W-1:0]  min_len,
    output logic              ready,
    output logic              valid,
    output logic [LEN_W-1:0]  block_cnt,
    output logic [LEN_W-1:0]  max_len
);

    localparam int K     = DATA_W / CHUNK_W;
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

    state_t             state_reg;
    logic [DATA_W-1:0]  data_reg;
    logic [LEN_W-1:0]   min_len_reg;
    logic [LEN_W-1:0]   run_len_reg;
    logic [LEN_W-1:0]   cnt_reg;
    logic [LEN_W-1:0]   max_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               ready_reg;
    logic               valid_reg;
    logic [LEN_W-1:0]   block_cnt_reg;
    logic [LEN_W-1:0]   max_len_reg;

    logic               last_chunk;
    logic [LEN_W-1:0]   cnt_inc;
    logic [LEN_W-1:0]   run_len_next;
    logic [LEN_W-1:0]   chunk_max;
    logic [LEN_W-1:0]   cnt_next;
    logic [LEN_W-1:0]   max_next;

    assign last_chunk = (idx_reg == IDX_W'(K - 1));

    // data_reg shifts right once per scan cycle, so the current chunk is
    // always in its low bits.
    bit_block_chunk_scan #(
        .CHUNK_W (CHUNK_W),
        .LEN_W   (LEN_W)
    ) u_scan (
        .chunk       (data_reg[CHUNK_W-1:0]),
        .run_len_in  (run_len_reg),
        .min_len     (min_len_reg),
        .last_chunk  (last_chunk),
        .cnt_inc     (cnt_inc),
        .run_len_out (run_len_next),
        .chunk_max   (chunk_max)
    );

    assign cnt_next = cnt_reg + cnt_inc;
    assign max_next = (chunk_max > max_reg) ? chunk_max : max_reg;

    // Handshake FSM with accumulators. The final chunk's contribution goes
    // straight into the output registers, so valid rises on the last scan
    // edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            data_reg      <= '0;
            min_len_reg   <= '0;
            run_len_reg   <= '0;
            cnt_reg       <= '0;
            max_reg       <= '0;
            idx_reg       <= '0;
            ready_reg     <= 1'b1;
            valid_reg     <= 1'b0;
            block_cnt_reg <= '0;
            max_len_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    valid_reg <= 1'b0;
                    if (data_enb) begin
                        data_reg    <= data ^ {DATA_W{polarity}};
                        min_len_reg <= min_len;
                        run_len_reg <= '0;
                        cnt_reg     <= '0;
                        max_reg     <= '0;
                        idx_reg     <= '0;
                        ready_reg   <= 1'b0;
                        state_reg   <= SCAN;
                    end
                end
                SCAN: begin
                    data_reg    <= data_reg >> CHUNK_W;
                    run_len_reg <= run_len_next;
                    cnt_reg     <= cnt_next;
                    max_reg     <= max_next;
                    idx_reg     <= idx_reg + IDX_W'(1);
                    if (last_chunk) begin
                        block_cnt_reg <= cnt_next;
                        max_len_reg   <= max_next;
                        valid_reg     <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    valid_reg <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    ready_reg <= 1'b1;
                    valid_reg <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ready     = ready_reg;
    assign valid     = valid_reg;
    assign block_cnt = block_cnt_reg;
    assign max_len   = max_len_reg;

endmodule
